// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes one-hot RV32I command descriptors into 32-bit
//             instruction words and queues them in a small output FIFO.
//             Illegal commands are consumed but flagged on a sticky error.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmdValid,
    output logic              o_cmdReady,
    input  logic [10:0]       i_cmdType,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    input  logic              i_errClr,
    output logic              o_instrValid,
    input  logic              i_instrReady,
    output logic [XLEN-1:0]   o_instr,
    output logic [$clog2(DEPTH):0] o_level,
    output logic              o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // FIFO state
    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            err;

    // Command decode
    logic            one_hot;
    logic            is_i, is_u, is_s, is_b, is_j, is_r;
    logic            is_shift;
    logic            range_ok;
    logic            legal;
    logic [6:0]      opcode;
    logic [31:0]     enc_word;
    logic            accept;
    logic            push;
    logic            pop;

    // Ready depends only on the registered level, never on the consumer side
    assign o_cmdReady   = (level != FULL_LEVEL);
    assign o_instrValid = (level != '0);
    assign o_level      = level;
    assign o_err        = err;
    assign o_instr      = o_instrValid ? mem[rd_ptr] : '0;

    assign accept = i_cmdValid && o_cmdReady;
    assign push   = accept && legal;
    assign pop    = o_instrValid && i_instrReady;

    // Class decode, opcode selection and legality checks
    always_comb begin
        one_hot  = (i_cmdType != '0) && ((i_cmdType & (i_cmdType - 11'd1)) == '0);
        is_i     = |i_cmdType[4:0];
        is_u     = i_cmdType[5] | i_cmdType[6];
        is_s     = i_cmdType[7];
        is_b     = i_cmdType[8];
        is_j     = i_cmdType[9];
        is_r     = i_cmdType[10];
        // Immediate shifts take their upper bits from funct7, shamt from imm
        is_shift = i_cmdType[2] && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

        // Only meaningful when one_hot holds; OR of masks is exact then
        opcode = ({7{i_cmdType[0]}}  & 7'h67) | ({7{i_cmdType[1]}}  & 7'h03) |
                 ({7{i_cmdType[2]}}  & 7'h13) | ({7{i_cmdType[3]}}  & 7'h73) |
                 ({7{i_cmdType[4]}}  & 7'h0F) | ({7{i_cmdType[5]}}  & 7'h37) |
                 ({7{i_cmdType[6]}}  & 7'h17) | ({7{i_cmdType[7]}}  & 7'h23) |
                 ({7{i_cmdType[8]}}  & 7'h63) | ({7{i_cmdType[9]}}  & 7'h6F) |
                 ({7{i_cmdType[10]}} & 7'h33);

        // Signed-range test: all bits above the field's sign bit match it
        range_ok = 1'b1;
        if (is_i || is_s)
            range_ok = (&i_imm[31:11]) || !(|i_imm[31:11]);
        else if (is_b)
            range_ok = (&i_imm[31:12]) || !(|i_imm[31:12]);
        else if (is_j)
            range_ok = (&i_imm[31:20]) || !(|i_imm[31:20]);
        else if (is_u)
            range_ok = (i_imm[11:0] == 12'h000);

        legal = one_hot && range_ok && !((is_b || is_j) && i_imm[0]);
    end

    // Field packing for the selected instruction format
    always_comb begin
        enc_word = '0;
        if (is_r)
            enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, opcode};
        else if (is_i && is_shift)
            enc_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, opcode};
        else if (is_i)
            enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, opcode};
        else if (is_s)
            enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], opcode};
        else if (is_b)
            enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], opcode};
        else if (is_u)
            enc_word = {i_imm[31:12], i_rd, opcode};
        else if (is_j)
            enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, opcode};
    end

    // Storage array; contents are don't-care while level is zero
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= XLEN'(enc_word);
    end

    // Pointers and occupancy; power-of-two depth makes wrap implicit
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    // Sticky rejection flag; a new rejection beats a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            err <= 1'b0;
        else if (accept && !legal)
            err <= 1'b1;
        else if (i_errClr)
            err <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Directed self-checking bench for instr_encoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    localparam logic [10:0] T_JALR   = 11'h001;
    localparam logic [10:0] T_LOAD   = 11'h002;
    localparam logic [10:0] T_OPIMM  = 11'h004;
    localparam logic [10:0] T_SYSTEM = 11'h008;
    localparam logic [10:0] T_LUI    = 11'h020;
    localparam logic [10:0] T_STORE  = 11'h080;
    localparam logic [10:0] T_BRANCH = 11'h100;
    localparam logic [10:0] T_JAL    = 11'h200;
    localparam logic [10:0] T_OP     = 11'h400;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_cmdValid;
    logic              o_cmdReady;
    logic [10:0]       i_cmdType;
    logic [4:0]        i_rd, i_rs1, i_rs2;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [31:0]       i_imm;
    logic              i_errClr;
    logic              o_instrValid;
    logic              i_instrReady;
    logic [XLEN-1:0]   o_instr;
    logic [$clog2(DEPTH):0] o_level;
    logic              o_err;

    int n_vec  = 0;
    int n_miss = 0;

    instr_encoder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cmdValid  (i_cmdValid),
        .o_cmdReady  (o_cmdReady),
        .i_cmdType   (i_cmdType),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_imm       (i_imm),
        .i_errClr    (i_errClr),
        .o_instrValid(o_instrValid),
        .i_instrReady(i_instrReady),
        .o_instr     (o_instr),
        .o_level     (o_level),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a command for one clock edge; called and returns at negedge
    task automatic send(input logic [10:0] ty, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        i_cmdValid = 1'b1;
        i_cmdType  = ty;
        i_rd       = rd;
        i_rs1      = rs1;
        i_rs2      = rs2;
        i_funct3   = f3;
        i_funct7   = f7;
        i_imm      = imm;
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmdValid = 1'b0;
    endtask

    // Check the head word, then consume it
    task automatic take(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {31'd0, o_instrValid}, 32'd1);
        chk(tag, o_instr, exp);
        i_instrReady = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_instrReady = 1'b0;
    endtask

    task automatic clear_err();
        i_errClr = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_errClr = 1'b0;
    endtask

    initial begin
        i_rstn = 1'b0; i_cmdValid = 1'b0; i_cmdType = '0;
        i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_funct3 = '0; i_funct7 = '0;
        i_imm = '0; i_errClr = 1'b0; i_instrReady = 1'b0;

        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, o_instrValid}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_err",   {31'd0, o_err}, 32'd0);
        chk("rst_ready", {31'd0, o_cmdReady}, 32'd1);
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Basic encodings, one cycle latency
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("addi_level", 32'(o_level), 32'd1);
        take("addi", 32'h00510093);
        send(T_LUI, 5'd5, 5'd9, 5'd9, 3'd7, 7'd0, 32'h12345000);
        take("lui", 32'h123452B7);
        send(T_JAL, 5'd1, 5'd9, 5'd9, 3'd7, 7'd0, 32'd8);
        take("jal", 32'h008000EF);
        send(T_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd4);
        take("sw", 32'h00312223);
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
        take("srai", 32'h40315093);
        send(T_SYSTEM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        take("ecall", 32'h00000073);
        send(T_SYSTEM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        take("ebreak", 32'h00100073);
        chk("sys_err", {31'd0, o_err}, 32'd0);

        // Rejections
        send(T_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        chk("br_odd_err", {31'd0, o_err}, 32'd1);
        chk("br_odd_level", 32'(o_level), 32'd0);
        clear_err();
        chk("clr_err", {31'd0, o_err}, 32'd0);
        send(11'h003, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0);
        chk("two_hot_err", {31'd0, o_err}, 32'd1);
        chk("two_hot_level", 32'(o_level), 32'd0);
        clear_err();
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("imm_range_err", {31'd0, o_err}, 32'd1);
        chk("imm_range_level", 32'(o_level), 32'd0);
        clear_err();
        send(T_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
        chk("lui_low_err", {31'd0, o_err}, 32'd1);
        // Reject and clear in the same cycle: set wins
        i_errClr = 1'b1;
        send(T_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        i_errClr = 1'b0;
        chk("set_wins_err", {31'd0, o_err}, 32'd1);
        clear_err();
        chk("clr2_err", {31'd0, o_err}, 32'd0);

        // Fill, pop at full, push+pop, wrap ordering
        send(T_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFF);
        send(T_OP, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
        chk("full_ready", {31'd0, o_cmdReady}, 32'd0);
        chk("full_level", 32'(o_level), 32'(DEPTH));
        // Offer C while popping at full: only the pop happens
        i_instrReady = 1'b1;
        i_cmdValid = 1'b1; i_cmdType = T_LOAD; i_rd = 5'd7; i_rs1 = 5'd8;
        i_rs2 = 5'd0; i_funct3 = 3'd2; i_funct7 = 7'd0; i_imm = 32'hFFFF_FFFC;
        chk("full_head", o_instr, 32'h002081B3);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("popfull_level", 32'(o_level), 32'(DEPTH - 1));
        chk("popfull_ready", {31'd0, o_cmdReady}, 32'd1);
        chk("popfull_head", o_instr, 32'h40628233);
        // Now C is accepted while B pops: level unchanged
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmdValid = 1'b0; i_instrReady = 1'b0;
        chk("pushpop_level", 32'(o_level), 32'(DEPTH - 1));
        send(T_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd16);
        chk("refill_level", 32'(o_level), 32'(DEPTH));
        take("wrap_c", 32'hFFC42383);
        take("wrap_d", 32'h00209863);
        chk("drain_level", 32'(o_level), 32'd0);

        // Asynchronous reset with entries queued
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd6);
        chk("pre_rst_level", 32'(o_level), 32'd2);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_instrValid}, 32'd0);
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_instr", o_instr, 32'd0);
        chk("arst_ready", {31'd0, o_cmdReady}, 32'd1);
        @(negedge i_clk);
        send(T_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
        chk("in_rst_level", 32'(o_level), 32'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("post_rst_level", 32'(o_level), 32'd0);
        send(T_JALR, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd4);
        take("jalr", 32'h004100E7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
